// File: rtl/arm_hazard_unit.sv
// Hazard unit for a 5-stage ARM pipeline: tracks EX/MEM/WB destinations to drive
// operand forwarding, load-use and CPSR stalls, and the post-SWI halt.
module arm_hazard_unit #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [2:0]             id_mask,
  input  logic [11:0]            id_reg_num,
  input  logic                   id_rd_we,
  input  logic [3:0]             id_rd_num,
  input  logic                   id_is_load,
  input  logic                   id_cpsr_we,
  input  logic                   id_cond_use,
  input  logic                   id_halt,
  input  logic                   flush,
  output logic                   stall,
  output logic [5:0]             fwd_sel,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [3:0] rd;
    logic       is_load;
    logic       cpsr_we;
    logic       halt;
  } shadow_t;

  shadow_t                r_ex, r_mem, r_wb;
  shadow_t                w_id;
  logic                   r_halt_blk;
  logic                   r_halted;
  logic [STALL_CNT_W-1:0] r_cnt;

  logic [2:0] w_rel, w_hit_ex, w_hit_mem, w_hit_wb;
  logic       w_load_use, w_cpsr_haz, w_haz, w_capture;

  always_comb begin
    w_id         = '0;
    w_id.valid   = 1'b1;
    w_id.we      = id_rd_we;
    w_id.rd      = id_rd_num;
    w_id.is_load = id_is_load;
    w_id.cpsr_we = id_cpsr_we;
    w_id.halt    = id_halt;
  end

  // r15 reads come from the PC path, never from the forwarding network
  for (genvar k = 0; k < 3; k++) begin : g_slot
    logic [3:0] w_reg;
    assign w_reg        = id_reg_num[4*k +: 4];
    assign w_rel[k]     = id_valid & id_mask[k] & (w_reg != 4'hF);
    assign w_hit_ex[k]  = r_ex.valid  & r_ex.we  & (r_ex.rd  == w_reg);
    assign w_hit_mem[k] = r_mem.valid & r_mem.we & (r_mem.rd == w_reg);
    assign w_hit_wb[k]  = r_wb.valid  & r_wb.we  & (r_wb.rd  == w_reg);
    assign fwd_sel[2*k +: 2] = !w_rel[k]    ? 2'b00 :
                               w_hit_ex[k]  ? 2'b01 :
                               w_hit_mem[k] ? 2'b10 :
                               w_hit_wb[k]  ? 2'b11 : 2'b00;
  end

  assign w_load_use = (|(w_rel & w_hit_ex)) & r_ex.is_load;
  assign w_cpsr_haz = id_cond_use & r_ex.valid & r_ex.cpsr_we;
  assign w_haz      = w_load_use | w_cpsr_haz;
  assign stall      = w_haz | r_halt_blk;
  assign w_capture  = id_valid & ~stall & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex       <= '0;
      r_mem      <= '0;
      r_wb       <= '0;
      r_halt_blk <= 1'b0;
      r_halted   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_capture ? w_id : '0;
      if (w_capture && id_halt) r_halt_blk <= 1'b1;
      if (r_wb.valid && r_wb.halt) r_halted <= 1'b1;
      // the halt block is a permanent freeze, not a hazard, so it is not counted
      if (w_haz && !r_halt_blk && r_cnt != '1) r_cnt <= r_cnt + STALL_CNT_W'(1);
    end
  end

  assign halted      = r_halted;
  assign stall_count = r_cnt;

endmodule

// File: tb/tb_arm_hazard_unit.sv
// Directed checks of forwarding, stalls, halt and reset for arm_hazard_unit.
module tb_arm_hazard_unit;

  logic        clk, rst;
  logic        id_valid, id_rd_we, id_is_load, id_cpsr_we, id_cond_use, id_halt, flush;
  logic [2:0]  id_mask;
  logic [11:0] id_reg_num;
  logic [3:0]  id_rd_num;
  logic        stall, halted, stall2, halted2;
  logic [5:0]  fwd_sel, fwd2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int ncmp = 0;
  int nerr = 0;

  arm_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_mask(id_mask), .id_reg_num(id_reg_num),
    .id_rd_we(id_rd_we), .id_rd_num(id_rd_num), .id_is_load(id_is_load),
    .id_cpsr_we(id_cpsr_we), .id_cond_use(id_cond_use), .id_halt(id_halt), .flush(flush),
    .stall(stall), .fwd_sel(fwd_sel), .halted(halted), .stall_count(cnt)
  );

  arm_hazard_unit #(.STALL_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_mask(id_mask), .id_reg_num(id_reg_num),
    .id_rd_we(id_rd_we), .id_rd_num(id_rd_num), .id_is_load(id_is_load),
    .id_cpsr_we(id_cpsr_we), .id_cond_use(id_cond_use), .id_halt(id_halt), .flush(flush),
    .stall(stall2), .fwd_sel(fwd2), .halted(halted2), .stall_count(cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setid(input logic v, input logic [2:0] m, input logic [11:0] r,
                       input logic we, input logic [3:0] rd, input logic ld,
                       input logic cp, input logic cu, input logic hl);
    id_valid = v; id_mask = m; id_reg_num = r; id_rd_we = we; id_rd_num = rd;
    id_is_load = ld; id_cpsr_we = cp; id_cond_use = cu; id_halt = hl;
    #1;
  endtask

  task automatic idle();
    setid(1'b0, 3'b000, 12'h000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    idle();
    #1;
    chk("rst_stall",  32'(stall),   0);
    chk("rst_fwd",    32'(fwd_sel), 0);
    chk("rst_halted", 32'(halted),  0);
    chk("rst_count",  32'(cnt),     0);
    tick();
    rst = 1'b0;

    // forwarding distance: EX, MEM, WB, then register file
    setid(1'b1, 3'b000, 12'h000, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add_nostall", 32'(stall), 0);
    tick();
    setid(1'b1, 3'b001, 12'h001, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fwd_ex",  32'(fwd_sel), 32'h01);
    chk("fwd_ex_stall", 32'(stall), 0);
    tick(); setid(1'b1, 3'b001, 12'h001, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fwd_mem", 32'(fwd_sel), 32'h02);
    tick(); setid(1'b1, 3'b001, 12'h001, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fwd_wb",  32'(fwd_sel), 32'h03);
    tick(); setid(1'b1, 3'b001, 12'h001, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fwd_rf",  32'(fwd_sel), 32'h00);

    // load-use on slot1
    tick(); idle(); tick(); tick(); tick();
    setid(1'b1, 3'b000, 12'h000, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    setid(1'b1, 3'b010, 12'h020, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_stall",     32'(stall),   1);
    chk("lu_fwd_ex",    32'(fwd_sel), 32'h04);
    chk("lu_cnt_pre",   32'(cnt),     0);
    tick();
    chk("lu_released",  32'(stall),   0);
    chk("lu_fwd_mem",   32'(fwd_sel), 32'h08);
    chk("lu_cnt",       32'(cnt),     1);
    chk("lu_cnt_w2",    32'(cnt2),    1);

    // CPSR dependency: conditional stalls once, AL does not
    tick(); idle(); tick(); tick(); tick();
    setid(1'b1, 3'b000, 12'h000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    setid(1'b1, 3'b000, 12'h000, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("cpsr_stall", 32'(stall), 1);
    tick();
    chk("cpsr_release", 32'(stall), 0);
    tick();
    setid(1'b1, 3'b000, 12'h000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    setid(1'b1, 3'b000, 12'h000, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("cpsr_al_nostall", 32'(stall), 0);
    chk("cpsr_cnt", 32'(cnt), 2);
    chk("cpsr_cnt_w2", 32'(cnt2), 2);

    // EX priority over MEM; r15 and unmasked slots never forward
    tick(); idle(); tick(); tick(); tick();
    setid(1'b1, 3'b000, 12'h000, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    setid(1'b1, 3'b000, 12'h000, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    setid(1'b1, 3'b100, 12'h300, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("prio_ex", 32'(fwd_sel), 32'h10);
    tick();
    setid(1'b1, 3'b001, 12'h03F, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("r15_and_mask", 32'(fwd_sel), 32'h00);
    chk("r15_nostall",  32'(stall),   0);

    // flushed producer never forwards
    tick(); idle(); tick(); tick(); tick();
    setid(1'b1, 3'b000, 12'h000, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    setid(1'b1, 3'b001, 12'h006, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_ex_bubble", 32'(fwd_sel), 32'h00);
    tick(); setid(1'b1, 3'b001, 12'h006, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_mem_bubble", 32'(fwd_sel), 32'h00);

    // load-use coinciding with flush: stall still reported and counted
    tick(); idle(); tick(); tick(); tick();
    setid(1'b1, 3'b000, 12'h000, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    setid(1'b1, 3'b001, 12'h005, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(stall), 1);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_after_stall", 32'(stall),   0);
    chk("flush_fwd_mem",     32'(fwd_sel), 32'h02);
    chk("flush_cnt",         32'(cnt),     3);

    // five more load-use stalls: wide counter keeps counting, 2-bit one saturates
    tick(); idle(); tick();
    for (int i = 0; i < 5; i++) begin
      setid(1'b1, 3'b000, 12'h000, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      setid(1'b1, 3'b001, 12'h007, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("sat_stall_%0d", i), 32'(stall), 1);
      tick();
      tick();
    end
    chk("sat_cnt16", 32'(cnt),  8);
    chk("sat_cnt2",  32'(cnt2), 3);

    // SWI: permanent stall, halted three cycles after capture, no counting
    idle(); tick();
    setid(1'b1, 3'b000, 12'h000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("swi_nostall", 32'(stall), 0);
    tick();
    setid(1'b1, 3'b001, 12'h001, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("halt_blk_stall", 32'(stall),  1);
    chk("halt_h0",        32'(halted), 0);
    tick();
    chk("halt_h1", 32'(halted), 0);
    tick();
    chk("halt_h2", 32'(halted), 0);
    tick();
    chk("halt_h3",     32'(halted), 1);
    chk("halt_stall3", 32'(stall),  1);
    chk("halt_cnt",    32'(cnt),    8);
    tick();
    chk("halt_sticky", 32'(halted), 1);
    rst = 1'b1;
    #1;
    chk("arst_halted", 32'(halted), 0);
    chk("arst_stall",  32'(stall),  0);
    chk("arst_cnt",    32'(cnt),    0);
    #1;
    rst = 1'b0;

    // reset in the middle of a load-use stall discards the load
    tick();
    setid(1'b1, 3'b000, 12'h000, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    setid(1'b1, 3'b001, 12'h008, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_stall", 32'(stall), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(stall), 0);
    #1;
    rst = 1'b0;
    tick();
    setid(1'b1, 3'b001, 12'h008, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_stall", 32'(stall),   0);
    chk("post_rst_fwd",   32'(fwd_sel), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/arm_hazard_unit.md
ARM_HAZARD_UNIT -- requirements
Module: arm_hazard_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: STALL_CNT_W, default 16, width of the saturating stall counter.
REQ-003 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 id_valid  input  1  the ID stage holds a real instruction.
REQ-006 id_mask  input  3  per-slot flag: that read slot is a real source register.
REQ-007 id_reg_num  input  12  three 4-bit read register numbers; slot k is bits [4k+3:4k].
REQ-008 id_rd_we  input  1  the ID instruction writes a destination register.
REQ-009 id_rd_num  input  4  destination register number.
REQ-010 id_is_load  input  1  the ID instruction is a load (result ready only after MEM).
REQ-011 id_cpsr_we  input  1  the ID instruction writes the CPSR flags.
REQ-012 id_cond_use  input  1  the ID instruction condition is not AL (it reads the CPSR).
REQ-013 id_halt  input  1  the ID instruction is SWI/halt.
REQ-014 flush  input  1  squash the instruction entering EX this cycle (branch redirect).
REQ-015 stall  output  1  hold PC and IF/ID; a bubble enters EX.
REQ-016 fwd_sel  output  6  2 bits per slot: 00 register file, 01 EX result, 10 MEM result, 11 WB result.
REQ-017 halted  output  1  a halt instruction has retired from WB.
REQ-018 stall_count  output  STALL_CNT_W  count of cycles in which stall was asserted.

Function
REQ-019 The block SHALL keep three shadow entries, EX, MEM and WB, each holding {valid, we, rd, is_load, cpsr_we, halt}.
REQ-020 Each cycle: WB<=MEM and MEM<=EX. EX<=the ID fields when id_valid=1, stall=0 and flush=0; otherwise EX<=a bubble with valid=0.
REQ-021 A slot is hazard-relevant when id_valid=1, its mask bit is 1 and its register number is not 15.
REQ-022 For each relevant slot, fwd_sel SHALL select the youngest valid stage with we=1 and rd equal to the slot register. Priority is EX, then MEM, then WB; if none match, the value is 00.
REQ-023 Register 15 reads and irrelevant slots SHALL always give fwd_sel=00.
REQ-024 Load-use stall: stall SHALL be 1 when any relevant slot matches a valid EX entry that has is_load=1 and we=1.
REQ-025 CPSR stall: stall SHALL be 1 when id_cond_use=1 and valid EX has cpsr_we=1.
REQ-026 stall, fwd_sel and the hazard decision SHALL be combinational from the current shadow state and the ID inputs. There is zero-cycle latency.
REQ-027 A load-use or CPSR stall SHALL last exactly 1 cycle, because the bubble clears the EX match.
REQ-028 When stall and flush are both 1, flush SHALL win the EX entry (bubble) and stall SHALL still be reported.
REQ-029 After a halt entry is captured into EX, the block SHALL block any new EX capture: stall SHALL stay 1 until reset.
REQ-030 halted SHALL become 1 on the cycle after the halt entry reaches WB and SHALL stay 1 (sticky) until reset.
REQ-031 stall_count SHALL increment on each cycle with stall=1 and SHALL saturate at all-ones without wrapping.
REQ-032 Stalls caused by the post-halt block SHALL NOT increment stall_count.
REQ-033 Stage shift SHALL continue every cycle, including during stall.

Reset
REQ-034 On rst=1, all valid flags SHALL be 0 and stall=0, fwd_sel=0, halted=0, stall_count=0 immediately, without waiting for a clock.
REQ-035 Reset mid-stall SHALL drop stall in the same cycle, and the in-flight shadow contents SHALL be discarded.

Verification
REQ-036 ADD r1 (we, rd=1), then next cycle SUB reading r1 in slot0 -> fwd_sel[1:0]=01, stall=0. One cycle later, an instruction reading r1 -> 10; two cycles later -> 11; three cycles later -> 00.
REQ-037 LDR r2, then immediately ADD reading r2 in slot1 -> stall=1 for 1 cycle, then fwd_sel[3:2]=10, stall=0, stall_count=1.
REQ-038 CMP (cpsr_we=1), then MOVEQ (id_cond_use=1) -> stall=1 for 1 cycle; with an AL condition instead -> stall=0.
REQ-039 Writes to r3 in both EX and MEM, and ID reads r3 -> fwd_sel=01 (EX priority). ID reads r15 with r15 in EX -> 00.
REQ-040 SWI captured -> stall stays 1; halted=1 three cycles after capture; stall_count unchanged. Assert rst -> halted=0 and stall=0 asynchronously.
REQ-041 With STALL_CNT_W=2, five load-use stalls -> stall_count saturates at 3.
